// File: rtl/key_search_dispatcher.sv
// Launches four key-search cores on disjoint ranges, stops the rest once one of them finds the key, and reports the result.
// Optional macro DISPATCH_TIMEOUT_EN adds a watchdog that aborts a SEARCH running longer than TIMEOUT_CYCLES.
module key_search_dispatcher #(
  parameter int          KEY_WIDTH      = 24,
  parameter int          CORE_SPAN_LOG2 = 20,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic [3:0]             core_start,
  output logic [4*KEY_WIDTH-1:0] core_base,
  output logic [3:0]             core_stop,
  input  logic [3:0]             core_done,
  input  logic [3:0]             core_found,
  output logic [3:0]             success_state,
  output logic                   busy,
  output logic                   search_done,
  output logic                   search_fail
);

  typedef enum logic [2:0] {IDLE, LAUNCH, SEARCH, ABORT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             core_start_q, core_start_d;
  logic [3:0]             core_stop_q, core_stop_d;
  logic [4*KEY_WIDTH-1:0] core_base_q, core_base_d;
  logic [3:0]             success_q, success_d;
  logic [3:0]             pending_q, pending_d;
  logic                   busy_q, busy_d;
  logic                   search_done_q, search_done_d;
  logic                   search_fail_q, search_fail_d;

  logic [4*KEY_WIDTH-1:0] base_init;
  logic [3:0]             winner;
  logic                   timeout_hit;

  // Core gi scans from gi * 2^CORE_SPAN_LOG2.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_base
      localparam logic [KEY_WIDTH-1:0] BASE = KEY_WIDTH'(gi) << CORE_SPAN_LOG2;
      assign base_init[gi*KEY_WIDTH +: KEY_WIDTH] = BASE;
    end
  endgenerate

  // Isolate the lowest set bit so the winner is always one-hot.
  assign winner = core_found & (~core_found + 4'd1);

`ifdef DISPATCH_TIMEOUT_EN
  logic [31:0] timeout_cnt_q, timeout_cnt_d;

  assign timeout_hit = (state_q == SEARCH) && (timeout_cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    timeout_cnt_d = timeout_cnt_q;
    if (state_q == LAUNCH) begin
      timeout_cnt_d = 32'd0;
    end else if (state_q == SEARCH) begin
      timeout_cnt_d = timeout_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_cnt_q <= 32'd0;
    end else begin
      timeout_cnt_q <= timeout_cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    core_start_d  = 4'b0000;
    core_stop_d   = 4'b0000;
    core_base_d   = core_base_q;
    success_d     = success_q;
    pending_d     = pending_q;
    busy_d        = busy_q;
    search_done_d = search_done_q;
    search_fail_d = search_fail_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = LAUNCH;
          core_start_d  = 4'b1111;
          core_base_d   = base_init;
          success_d     = 4'b0000;
          pending_d     = 4'b0000;
          busy_d        = 1'b1;
          search_done_d = 1'b0;
          search_fail_d = 1'b0;
        end
      end
      LAUNCH: begin
        state_d = SEARCH;
      end
      SEARCH: begin
        // A found result outranks a simultaneous done, even on the same core.
        if (|core_found) begin
          state_d     = ABORT;
          success_d   = winner;
          pending_d   = ~winner & ~core_done;
          core_stop_d = ~winner & ~core_done;
        end else if (&core_done) begin
          state_d       = DONE;
          success_d     = 4'b0000;
          busy_d        = 1'b0;
          search_done_d = 1'b1;
          search_fail_d = 1'b1;
        end else if (timeout_hit) begin
          state_d     = ABORT;
          success_d   = 4'b0000;
          pending_d   = ~core_done;
          core_stop_d = ~core_done;
        end
      end
      ABORT: begin
        if ((core_done & pending_q) == pending_q) begin
          state_d       = DONE;
          busy_d        = 1'b0;
          search_done_d = 1'b1;
          search_fail_d = ~|success_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      core_start_q  <= 4'b0000;
      core_stop_q   <= 4'b0000;
      core_base_q   <= '0;
      success_q     <= 4'b0000;
      pending_q     <= 4'b0000;
      busy_q        <= 1'b0;
      search_done_q <= 1'b0;
      search_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      core_start_q  <= core_start_d;
      core_stop_q   <= core_stop_d;
      core_base_q   <= core_base_d;
      success_q     <= success_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      search_done_q <= search_done_d;
      search_fail_q <= search_fail_d;
    end
  end

  assign core_start    = core_start_q;
  assign core_stop     = core_stop_q;
  assign core_base     = core_base_q;
  assign success_state = success_q;
  assign busy          = busy_q;
  assign search_done   = search_done_q;
  assign search_fail   = search_fail_q;

endmodule

// File: tb/tb_key_search_dispatcher.sv
// Directed bench for key_search_dispatcher: a table of found/done patterns plus hand-written reset and sequencing cases.
module tb_key_search_dispatcher;

  localparam int KW = 24;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [3:0]    core_start;
  logic [4*KW-1:0] core_base;
  logic [3:0]    core_stop;
  logic [3:0]    core_done;
  logic [3:0]    core_found;
  logic [3:0]    success_state;
  logic          busy;
  logic          search_done;
  logic          search_fail;

  int checks = 0;
  int errors = 0;

  key_search_dispatcher #(
    .KEY_WIDTH      (KW),
    .CORE_SPAN_LOG2 (20),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .core_start    (core_start),
    .core_base     (core_base),
    .core_stop     (core_stop),
    .core_done     (core_done),
    .core_found    (core_found),
    .success_state (success_state),
    .busy          (busy),
    .search_done   (search_done),
    .search_fail   (search_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] found;
    logic [3:0] done;
    logic [3:0] exp_succ;
    logic [3:0] exp_stop;
    logic       exp_fail;
  } vec_t;

  vec_t vecs [7];

  localparam logic [4*KW-1:0] EXP_BASE = {24'h300000, 24'h200000, 24'h100000, 24'h000000};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then check the LAUNCH cycle and the entry into SEARCH.
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("launch_core_start", core_start, 4'b1111);
    check("launch_busy", busy, 1'b1);
    check("launch_base", core_base, EXP_BASE);
    check("launch_clears_done", search_done, 1'b0);
    tick();
    check("search_core_start", core_start, 4'b0000);
    check("search_busy", busy, 1'b1);
  endtask

  initial begin
    vecs[0] = '{found: 4'b0100, done: 4'b0000, exp_succ: 4'b0100, exp_stop: 4'b1011, exp_fail: 1'b0};
    vecs[1] = '{found: 4'b1010, done: 4'b0000, exp_succ: 4'b0010, exp_stop: 4'b1101, exp_fail: 1'b0};
    vecs[2] = '{found: 4'b0001, done: 4'b0000, exp_succ: 4'b0001, exp_stop: 4'b1110, exp_fail: 1'b0};
    vecs[3] = '{found: 4'b1000, done: 4'b0110, exp_succ: 4'b1000, exp_stop: 4'b0001, exp_fail: 1'b0};
    vecs[4] = '{found: 4'b0010, done: 4'b0010, exp_succ: 4'b0010, exp_stop: 4'b1101, exp_fail: 1'b0};
    vecs[5] = '{found: 4'b0000, done: 4'b1111, exp_succ: 4'b0000, exp_stop: 4'b0000, exp_fail: 1'b1};
    vecs[6] = '{found: 4'b1111, done: 4'b1111, exp_succ: 4'b0001, exp_stop: 4'b0000, exp_fail: 1'b0};

    reset_n    = 1'b0;
    start      = 1'b0;
    core_found = 4'b0000;
    core_done  = 4'b0000;
    #12;
    check("rst_core_start", core_start, 4'b0000);
    check("rst_core_stop", core_stop, 4'b0000);
    check("rst_base", core_base, '0);
    check("rst_success", success_state, 4'b0000);
    check("rst_flags", {busy, search_done, search_fail}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("idle_no_start", {busy, core_start}, 5'b0);

    // Winner on core 2; ABORT must wait for every stopped core.
    launch();
    core_found = 4'b0100;
    tick();
    check("seqA_success", success_state, 4'b0100);
    check("seqA_stop", core_stop, 4'b1011);
    check("seqA_busy", {busy, search_done}, 2'b10);
    core_found = 4'b0000;
    core_done  = 4'b0001;
    tick();
    check("seqA_stop_pulse", core_stop, 4'b0000);
    check("seqA_waiting", {busy, search_done}, 2'b10);
    core_done = 4'b1011;
    tick();
    check("seqA_done", {busy, search_done, search_fail}, 3'b010);
    check("seqA_success_held", success_state, 4'b0100);
    core_done = 4'b0000;
    $display("seqA found=0100 success=%b done=%b fail=%b", success_state, search_done, search_fail);

    for (int i = 0; i < 7; i++) begin
      launch();
      core_found = vecs[i].found;
      core_done  = vecs[i].done;
      tick();
      check($sformatf("vec%0d_success", i), success_state, vecs[i].exp_succ);
      check($sformatf("vec%0d_stop", i), core_stop, vecs[i].exp_stop);
      if (vecs[i].exp_fail) begin
        check($sformatf("vec%0d_early_done", i), {busy, search_done, search_fail}, 3'b011);
      end else begin
        check($sformatf("vec%0d_abort_busy", i), {busy, search_done}, 2'b10);
      end
      core_found = 4'b0000;
      core_done  = 4'b1111;
      tick();
      check($sformatf("vec%0d_stop_clear", i), core_stop, 4'b0000);
      check($sformatf("vec%0d_final", i), {busy, search_done, search_fail}, {2'b01, vecs[i].exp_fail});
      core_done = 4'b0000;
      tick();
      tick();
      check($sformatf("vec%0d_hold", i), {search_done, search_fail, success_state},
            {1'b1, vecs[i].exp_fail, vecs[i].exp_succ});
      $display("vec%0d found=%b done=%b success=%b fail=%b", i, vecs[i].found, vecs[i].done,
               success_state, search_fail);
    end

    // Cores exhaust one after another with nothing found.
    launch();
    core_done = 4'b0001;
    tick();
    check("seqB_step1", {busy, search_done}, 2'b10);
    core_done = 4'b0011;
    tick();
    check("seqB_step2", {busy, search_done}, 2'b10);
    core_done = 4'b1111;
    tick();
    check("seqB_final", {busy, search_done, search_fail}, 3'b011);
    check("seqB_success", success_state, 4'b0000);
    check("seqB_stop", core_stop, 4'b0000);
    core_done = 4'b0000;
    $display("seqB staggered done fail=%b", search_fail);

    // Start held high while busy must not relaunch.
    start = 1'b1;
    tick();
    check("seqC_launch", core_start, 4'b1111);
    tick();
    check("seqC_ignore_launch", core_start, 4'b0000);
    tick();
    check("seqC_ignore_search", core_start, 4'b0000);
    check("seqC_busy", busy, 1'b1);
    start = 1'b0;
    $display("seqC start while busy core_start=%b", core_start);

    // Asynchronous reset while core_stop is high.
    core_found = 4'b0100;
    tick();
    check("seqD_stop_before", core_stop, 4'b1011);
    reset_n = 1'b0;
    #1;
    check("seqD_async_stop", core_stop, 4'b0000);
    check("seqD_async_out", {success_state, busy, search_done, search_fail, core_start}, 11'b0);
    check("seqD_async_base", core_base, '0);
    core_found = 4'b0000;
    tick();
    check("seqD_held_stop", core_stop, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("seqD_idle", {busy, search_done, core_start, core_stop}, 10'b0);
    launch();
    core_done = 4'b1111;
    tick();
    check("seqD_relaunch_done", {busy, search_done, search_fail}, 3'b011);
    core_done = 4'b0000;
    $display("seqD reset mid-search then relaunch done=%b", search_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
